param_dcache: RTL and testbench

PARAM_DCACHE -- requirements
Module: param_dcache

---
 rtl/param_dcache.sv | 165 ++++++++++++++++
 tb/tb_param_dcache.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with a single-line memory port.
// Tags, data, valid and dirty bits all live in flops; one request is serviced at a time.
module param_dcache #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINES  = 16,
   parameter int WORDS  = 4
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     en,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        din,
   input  logic [DATA_W/8-1:0]      be,
   output logic [DATA_W-1:0]        dout,
   output logic                     dc_hold,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W*WORDS-1:0]  mem_wdata,
   input  logic [DATA_W*WORDS-1:0]  mem_rdata,
   input  logic                     mem_ack
);

   localparam int BYTES  = DATA_W / 8;
   localparam int OFF_W  = $clog2(BYTES);
   localparam int WSEL_W = $clog2(WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = ADDR_W - OFF_W - WSEL_W - IDX_W;
   localparam int LINE_W = DATA_W * WORDS;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      ALLOCATE
   } state_t;

   state_t               state;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    din_q;
   logic                 we_q;
   logic [BYTES-1:0]     be_q;

   logic [LINES-1:0]     valid;
   logic [LINES-1:0]     dirty;
   logic [TAG_W-1:0]     tags  [LINES];
   logic [LINE_W-1:0]    lines [LINES];

   logic [TAG_W-1:0]     tag_q;
   logic [IDX_W-1:0]     idx_q;
   logic [WSEL_W-1:0]    wsel_q;
   logic [LINE_W-1:0]    cur_line;
   logic [TAG_W-1:0]     cur_tag;
   logic                 hit;

   assign tag_q    = addr_q[ADDR_W-1 -: TAG_W];
   assign idx_q    = addr_q[OFF_W+WSEL_W +: IDX_W];
   assign wsel_q   = addr_q[OFF_W +: WSEL_W];
   assign cur_line = lines[idx_q];
   assign cur_tag  = tags[idx_q];
   assign hit      = valid[idx_q] && (cur_tag == tag_q);

   // Byte-offset bits only matter to the CPU; the cache works in whole words.
   generate
      if (OFF_W > 0) begin : g_offset
         logic unused_offset;
         assign unused_offset = ^addr_q[OFF_W-1:0];
      end
   endgenerate

   // Outputs are decoded from the registered state; reset forces every one low at once.
   always_comb begin
      dout      = '0;
      dc_hold   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {tag_q, idx_q, {(OFF_W+WSEL_W){1'b0}}};
      mem_wdata = cur_line;
      if (RST_N) begin
         case (state)
            IDLE:      dc_hold = en;
            COMPARE: begin
               dc_hold = !hit;
               if (hit && !we_q)
                  dout = cur_line[int'(wsel_q)*DATA_W +: DATA_W];
            end
            WRITEBACK: begin
               dc_hold  = 1'b1;
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               mem_addr = {cur_tag, idx_q, {(OFF_W+WSEL_W){1'b0}}};
            end
            ALLOCATE: begin
               dc_hold = 1'b1;
               mem_req = 1'b1;
            end
            default: dc_hold = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         valid  <= '0;
         dirty  <= '0;
         addr_q <= '0;
         din_q  <= '0;
         we_q   <= 1'b0;
         be_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  addr_q <= addr;
                  din_q  <= din;
                  we_q   <= we;
                  be_q   <= be;
                  state  <= COMPARE;
               end
            end
            COMPARE: begin
               if (hit) begin
                  if (we_q)
                     dirty[idx_q] <= 1'b1;
                  state <= IDLE;
               end else if (valid[idx_q] && dirty[idx_q]) begin
                  state <= WRITEBACK;
               end else begin
                  state <= ALLOCATE;
               end
            end
            WRITEBACK: begin
               if (mem_ack)
                  state <= ALLOCATE;
            end
            ALLOCATE: begin
               if (mem_ack) begin
                  valid[idx_q] <= 1'b1;
                  dirty[idx_q] <= 1'b0;
                  state        <= COMPARE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag and data arrays carry no reset; an aborted fill never reaches them because
   // reset pulls the state out of ALLOCATE asynchronously.
   always_ff @(posedge CLK) begin
      if (state == ALLOCATE && mem_ack) begin
         lines[idx_q] <= mem_rdata;
         tags[idx_q]  <= tag_q;
      end else if (state == COMPARE && hit && we_q) begin
         for (int b = 0; b < BYTES; b++) begin
            if (be_q[b])
               lines[idx_q][int'(wsel_q)*DATA_W + b*8 +: 8] <= din_q[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_param_dcache.sv
// Bench for param_dcache: directed scenarios plus random traffic checked against an
// architectural memory image and a per-index residency model.
module tb_param_dcache;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          en = 1'b0;
   logic          we = 1'b0;
   logic [31:0]   addr = '0;
   logic [31:0]   din = '0;
   logic [3:0]    be = '0;
   logic [31:0]   dout;
   logic          dc_hold;
   logic          mem_req;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata = '0;
   logic          mem_ack = 1'b0;

   int total = 0;
   int bad = 0;

   logic [31:0] ext_mem  [bit [31:0]];
   logic [31:0] arch_mem [bit [31:0]];

   logic [31:0]  obs_rd;
   int           obs_cyc;
   int           obs_nwb;
   int           obs_nfill;
   logic [31:0]  obs_wb_addr;
   logic [127:0] obs_wb_data;
   logic [31:0]  obs_fill_addr;

   param_dcache #(.ADDR_W(32), .DATA_W(32), .LINES(16), .WORDS(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .en(en), .we(we), .addr(addr), .din(din), .be(be),
      .dout(dout), .dc_hold(dc_hold), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   function automatic logic [31:0] ext_rd(input logic [31:0] a);
      return ext_mem.exists(a) ? ext_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] arch_rd(input logic [31:0] a);
      return arch_mem.exists(a) ? arch_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] b);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++)
         if (b[k]) r[k*8 +: 8] = d[k*8 +: 8];
      return r;
   endfunction

   // One CPU request with a memory responder that acks each phase after 'lat' extra cycles.
   task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, input int lat);
      int phase;
      int guard;
      bit done;
      bit acked;
      logic [31:0]  p_addr;
      logic         p_we;
      logic [127:0] p_wdata;
      obs_rd = '0; obs_cyc = 0; obs_nwb = 0; obs_nfill = 0;
      obs_wb_addr = '0; obs_wb_data = '0; obs_fill_addr = '0;
      p_addr = '0; p_we = 1'b0; p_wdata = '0;
      @(negedge CLK);
      en = 1'b1; we = w; addr = a; din = d; be = b;
      #1;
      total++;
      if (dc_hold !== 1'b1) begin
         bad++;
         $display("FAIL hold_on_request addr=%h: dc_hold=%b required 1", a, dc_hold);
      end
      @(posedge CLK); #1;
      en = 1'b0;
      obs_cyc = 1; phase = 0; done = 0; guard = 0;
      while (!done && guard < 200) begin
         guard++;
         if (mem_req === 1'b1) begin
            if (phase == 0) begin
               p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
               if (mem_we) begin
                  obs_nwb++; obs_wb_addr = mem_addr; obs_wb_data = mem_wdata;
               end else begin
                  obs_nfill++; obs_fill_addr = mem_addr;
               end
            end else begin
               total++;
               if (mem_addr !== p_addr || mem_we !== p_we || dc_hold !== 1'b1 ||
                   (p_we && mem_wdata !== p_wdata)) begin
                  bad++;
                  $display("FAIL mem_stable: addr=%h we=%b hold=%b required addr=%h we=%b hold=1",
                           mem_addr, mem_we, dc_hold, p_addr, p_we);
               end
            end
            acked = 0;
            if (phase == lat) begin
               mem_ack = 1'b1;
               acked = 1;
               if (mem_we) begin
                  for (int k = 0; k < 4; k++)
                     ext_mem[mem_addr + 32'(4*k)] = mem_wdata[32*k +: 32];
               end else begin
                  mem_rdata = {ext_rd(mem_addr + 32'd12), ext_rd(mem_addr + 32'd8),
                               ext_rd(mem_addr + 32'd4), ext_rd(mem_addr)};
               end
            end
            phase++;
            obs_cyc++;
            @(posedge CLK); #1;
            mem_ack = 1'b0;
            if (acked) phase = 0;
         end else if (dc_hold === 1'b1) begin
            obs_cyc++;
            @(posedge CLK); #1;
         end else begin
            obs_rd = dout;
            done = 1;
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL access_timeout addr=%h: no completion after %0d cycles, required completion", a, guard);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      en = 1'b1; addr = 32'h100;
      repeat (2) @(negedge CLK);
      total++;
      if (dc_hold !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || dout !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: hold=%b req=%b we=%b dout=%h required 0 0 0 0",
                  dc_hold, mem_req, mem_we, dout);
      end
      en = 1'b0;
      RST_N = 1'b1;
      @(posedge CLK); #1;
      total++;
      if (dc_hold !== 1'b0 || mem_req !== 1'b0 || dout !== 32'h0) begin
         bad++;
         $display("FAIL idle_after_reset: hold=%b req=%b dout=%h required 0 0 0", dc_hold, mem_req, dout);
      end
   endtask

   task automatic test_fill();
      ext_mem[32'h100] = 32'h11; ext_mem[32'h104] = 32'h22;
      ext_mem[32'h108] = 32'h33; ext_mem[32'h10C] = 32'h44;
      run_access(1'b0, 32'h100, 32'h0, 4'h0, 2);
      total++;
      if (obs_nfill !== 1 || obs_nwb !== 0 || obs_fill_addr !== 32'h100) begin
         bad++;
         $display("FAIL fill_traffic: fills=%0d wbs=%0d addr=%h required 1 0 00000100",
                  obs_nfill, obs_nwb, obs_fill_addr);
      end
      total++;
      if (obs_rd !== 32'h11) begin
         bad++; $display("FAIL fill_read: dout=%h required 00000011", obs_rd);
      end
      total++;
      if (obs_cyc !== 5) begin
         bad++; $display("FAIL miss_latency: stall=%0d required 5", obs_cyc);
      end
   endtask

   task automatic test_read_hit();
      run_access(1'b0, 32'h104, 32'h0, 4'h0, 0);
      total++;
      if (obs_rd !== 32'h22 || obs_cyc !== 1 || obs_nfill !== 0 || obs_nwb !== 0) begin
         bad++;
         $display("FAIL read_hit: dout=%h stall=%0d fills=%0d wbs=%0d required 00000022 1 0 0",
                  obs_rd, obs_cyc, obs_nfill, obs_nwb);
      end
   endtask

   task automatic test_write_hit();
      run_access(1'b1, 32'h108, 32'hAABBCCDD, 4'b0011, 0);
      total++;
      if (obs_cyc !== 1 || obs_nfill !== 0 || obs_nwb !== 0) begin
         bad++;
         $display("FAIL write_hit: stall=%0d fills=%0d wbs=%0d required 1 0 0", obs_cyc, obs_nfill, obs_nwb);
      end
      run_access(1'b0, 32'h108, 32'h0, 4'h0, 0);
      total++;
      if (obs_rd !== 32'h0000CCDD) begin
         bad++; $display("FAIL write_merge: dout=%h required 0000ccdd", obs_rd);
      end
      run_access(1'b0, 32'h10C, 32'h0, 4'h0, 0);
      total++;
      if (obs_rd !== 32'h44) begin
         bad++; $display("FAIL neighbour_word: dout=%h required 00000044", obs_rd);
      end
   endtask

   task automatic test_writeback();
      run_access(1'b0, 32'h1100, 32'h0, 4'h0, 5);
      total++;
      if (obs_nwb !== 1 || obs_wb_addr !== 32'h100 || obs_wb_data[95:64] !== 32'h0000CCDD ||
          obs_wb_data[31:0] !== 32'h11) begin
         bad++;
         $display("FAIL writeback: wbs=%0d addr=%h w2=%h w0=%h required 1 00000100 0000ccdd 00000011",
                  obs_nwb, obs_wb_addr, obs_wb_data[95:64], obs_wb_data[31:0]);
      end
      total++;
      if (obs_nfill !== 1 || obs_fill_addr !== 32'h1100) begin
         bad++;
         $display("FAIL wb_then_fill: fills=%0d addr=%h required 1 00001100", obs_nfill, obs_fill_addr);
      end
      total++;
      if (obs_cyc !== 14 || obs_rd !== init_word(32'h1100)) begin
         bad++;
         $display("FAIL dirty_miss: stall=%0d dout=%h required 14 %h", obs_cyc, obs_rd, init_word(32'h1100));
      end
      @(negedge CLK); mem_ack = 1'b1;
      @(negedge CLK); mem_ack = 1'b0;
      total++;
      if (mem_req !== 1'b0 || dc_hold !== 1'b0) begin
         bad++; $display("FAIL ack_in_idle: req=%b hold=%b required 0 0", mem_req, dc_hold);
      end
      run_access(1'b0, 32'h1104, 32'h0, 4'h0, 0);
      total++;
      if (obs_cyc !== 1 || obs_rd !== init_word(32'h1104)) begin
         bad++;
         $display("FAIL hit_after_stray_ack: stall=%0d dout=%h required 1 %h", obs_cyc, obs_rd, init_word(32'h1104));
      end
   endtask

   task automatic test_reset_mid_alloc();
      int guard;
      @(negedge CLK);
      en = 1'b1; we = 1'b0; addr = 32'h2100;
      @(posedge CLK); #1;
      en = 1'b0;
      guard = 0;
      while (mem_req !== 1'b1 && guard < 10) begin
         @(posedge CLK); #1; guard++;
      end
      total++;
      if (mem_req !== 1'b1) begin
         bad++; $display("FAIL alloc_start: req=%b required 1", mem_req);
      end
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || dc_hold !== 1'b0 || dout !== 32'h0) begin
         bad++;
         $display("FAIL reset_abort: req=%b we=%b hold=%b dout=%h required 0 0 0 0",
                  mem_req, mem_we, dc_hold, dout);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      run_access(1'b0, 32'h1104, 32'h0, 4'h0, 0);
      total++;
      if (obs_nfill !== 1 || obs_nwb !== 0 || obs_rd !== init_word(32'h1104)) begin
         bad++;
         $display("FAIL miss_after_reset: fills=%0d wbs=%0d dout=%h required 1 0 %h",
                  obs_nfill, obs_nwb, obs_rd, init_word(32'h1104));
      end
      run_access(1'b0, 32'h100, 32'h0, 4'h0, 1);
      total++;
      if (obs_nfill !== 1 || obs_rd !== 32'h11) begin
         bad++; $display("FAIL reread_100: fills=%0d dout=%h required 1 00000011", obs_nfill, obs_rd);
      end
   endtask

   task automatic test_random();
      int          res_tag [4];
      bit          res_valid [4];
      bit          res_dirty [4];
      int          tag, idx, wsel, lat;
      logic        w;
      logic [31:0] a, d, exp_rd, vaddr;
      logic [3:0]  b;
      logic [127:0] exp_wdata;
      bit          exp_hit, exp_wb;
      int          exp_cyc;
      @(negedge CLK); RST_N = 1'b0;
      @(negedge CLK); RST_N = 1'b1;
      arch_mem = ext_mem;
      for (int i = 0; i < 4; i++) begin
         res_valid[i] = 0; res_dirty[i] = 0; res_tag[i] = 0;
      end
      for (int n = 0; n < 200; n++) begin
         tag  = $urandom_range(0, 3);
         idx  = $urandom_range(0, 3);
         wsel = $urandom_range(0, 3);
         lat  = $urandom_range(0, 3);
         w    = 1'($urandom_range(0, 1));
         d    = $urandom;
         b    = 4'($urandom_range(0, 15));
         a    = 32'(tag * 256 + idx * 16 + wsel * 4);
         exp_hit = res_valid[idx] && res_tag[idx] == tag;
         exp_wb  = !exp_hit && res_valid[idx] && res_dirty[idx];
         vaddr   = 32'(res_tag[idx] * 256 + idx * 16);
         exp_wdata = {arch_rd(vaddr + 32'd12), arch_rd(vaddr + 32'd8),
                      arch_rd(vaddr + 32'd4), arch_rd(vaddr)};
         exp_rd  = arch_rd(a);
         exp_cyc = exp_hit ? 1 : (exp_wb ? 4 + 2*lat : 3 + lat);
         run_access(w, a, d, b, lat);
         if (!w) begin
            total++;
            if (obs_rd !== exp_rd) begin
               bad++; $display("FAIL rand_read addr=%h: dout=%h required %h", a, obs_rd, exp_rd);
            end
         end
         total++;
         if (obs_nfill !== (exp_hit ? 0 : 1) || obs_nwb !== (exp_wb ? 1 : 0) || obs_cyc !== exp_cyc) begin
            bad++;
            $display("FAIL rand_traffic addr=%h: fills=%0d wbs=%0d stall=%0d required %0d %0d %0d",
                     a, obs_nfill, obs_nwb, obs_cyc, exp_hit ? 0 : 1, exp_wb ? 1 : 0, exp_cyc);
         end
         if (!exp_hit && obs_nfill == 1) begin
            total++;
            if (obs_fill_addr !== {a[31:4], 4'h0}) begin
               bad++; $display("FAIL rand_fill_addr: addr=%h required %h", obs_fill_addr, {a[31:4], 4'h0});
            end
         end
         if (exp_wb && obs_nwb == 1) begin
            total++;
            if (obs_wb_addr !== vaddr || obs_wb_data !== exp_wdata) begin
               bad++;
               $display("FAIL rand_writeback: addr=%h data=%h required %h %h",
                        obs_wb_addr, obs_wb_data, vaddr, exp_wdata);
            end
         end
         if (!exp_hit) begin
            res_valid[idx] = 1; res_tag[idx] = tag; res_dirty[idx] = 0;
         end
         if (w) begin
            res_dirty[idx] = 1;
            arch_mem[a] = merge(arch_rd(a), d, b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_read_hit();
      test_write_hit();
      test_writeback();
      test_reset_mid_alloc();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
